mem_port_arbiter: RTL

- Shares one single-ported, variable-latency memory between the instruction-fetch port and the data port of the MIPS pipelined CPU datapath.
- Sequences each access through a req/ack handshake with the memory.
- Returns read data through registered response buffers.
- Generates per-port stall signals that freeze the pipeline until that port's access completes.

---
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, data port and memory-side handshake of the port arbiter.
// Latency: none, wires only.
// Backpressure: stalls flow back to the CPU ports; the memory paces access via ram_req/ram_ack.
interface mem_port_arbiter_if;
  // CPU control
  logic        cpu_en;
  // Instruction-fetch port
  logic        inst_ren;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        inst_stall;
  // Data port
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic        mem_stall;
  // Memory side
  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_ack;
  logic [31:0] ram_rdata;
  // Status
  logic        busy;
  logic        timeout_err;

  // Arbiter side
  modport slave (
    input  cpu_en, inst_ren, inst_addr, mem_ren, mem_wen, mem_addr, mem_dout,
           ram_ack, ram_rdata,
    output inst_data, inst_stall, mem_din, mem_stall, ram_req, ram_we, ram_addr,
           ram_wdata, busy, timeout_err
  );

  // CPU plus memory side
  modport master (
    output cpu_en, inst_ren, inst_addr, mem_ren, mem_wen, mem_addr, mem_dout,
           ram_ack, ram_rdata,
    input  inst_data, inst_stall, mem_din, mem_stall, ram_req, ram_we, ram_addr,
           ram_wdata, busy, timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported variable-latency memory between fetch and data ports.
// Latency: grant, req/ack (>=1 cycle), one RESP cycle; 3 cycles with a zero-wait memory.
// Backpressure: per-port stall held until that port's RESP cycle; ram_req held until ram_ack or timeout.
module mem_port_arbiter #(
  parameter int MAX_DATA_RUN = 4,
  parameter int TIMEOUT      = 255
) (
  input logic              clk,
  input logic              cpu_rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX     = RUN_W'(MAX_DATA_RUN);
  localparam logic [7:0]       TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    INST_WAIT,
    DATA_WAIT,
    INST_RESP,
    DATA_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [7:0]        wait_q, wait_d;
  logic [7:0]        wait_inc;
  logic [31:0]       inst_data_q, inst_data_d;
  logic [31:0]       mem_din_q, mem_din_d;
  logic [31:0]       ram_addr_q, ram_addr_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;
  logic              ram_req_q, ram_req_d;
  logic              ram_we_q, ram_we_d;
  logic              timeout_err_q, timeout_err_d;
  logic              data_pend;
  logic              grant_data;
  logic              grant_inst;

  assign data_pend = bus.mem_ren | bus.mem_wen;
  assign wait_inc  = wait_q + 8'd1;

  // Next-state, grant decision, memory request registers and response capture
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    inst_data_d   = inst_data_q;
    mem_din_d     = mem_din_q;
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;
    ram_req_d     = ram_req_q;
    ram_we_d      = ram_we_q;
    timeout_err_d = timeout_err_q;
    grant_data    = 1'b0;
    grant_inst    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cpu_en) begin
          // Data wins unless it has used up its run while a fetch waits
          if (data_pend && ((run_q < RUN_MAX) || !bus.inst_ren)) begin
            grant_data = 1'b1;
          end else if (bus.inst_ren) begin
            grant_inst = 1'b1;
          end
        end
        if (grant_data) begin
          state_d     = DATA_WAIT;
          ram_req_d   = 1'b1;
          ram_we_d    = bus.mem_wen;
          ram_addr_d  = bus.mem_addr;
          ram_wdata_d = bus.mem_dout;
          wait_d      = 8'd0;
        end else if (grant_inst) begin
          state_d    = INST_WAIT;
          ram_req_d  = 1'b1;
          ram_we_d   = 1'b0;
          ram_addr_d = bus.inst_addr;
          wait_d     = 8'd0;
        end
      end
      INST_WAIT, DATA_WAIT: begin
        if (bus.ram_ack) begin
          ram_req_d = 1'b0;
          if (state_q == INST_WAIT) begin
            inst_data_d = bus.ram_rdata;
            state_d     = INST_RESP;
          end else begin
            // Stores leave the load register untouched
            if (!ram_we_q) mem_din_d = bus.ram_rdata;
            state_d = DATA_RESP;
          end
        end else begin
          wait_d = wait_inc;
          if (wait_inc == TIMEOUT_CNT) begin
            // Give up: release the stall without delivering data
            timeout_err_d = 1'b1;
            ram_req_d     = 1'b0;
            state_d       = (state_q == INST_WAIT) ? INST_RESP : DATA_RESP;
          end
        end
      end
      INST_RESP, DATA_RESP: state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // Consecutive-data-grant counter that bounds fetch starvation
  always_comb begin
    run_d = run_q;
    if (!bus.inst_ren || grant_inst) begin
      run_d = '0;
    end else if (grant_data && (run_q < RUN_MAX)) begin
      run_d = run_q + RUN_W'(1);
    end
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q       <= IDLE;
      run_q         <= '0;
      wait_q        <= 8'd0;
      inst_data_q   <= 32'd0;
      mem_din_q     <= 32'd0;
      ram_addr_q    <= 32'd0;
      ram_wdata_q   <= 32'd0;
      ram_req_q     <= 1'b0;
      ram_we_q      <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      run_q         <= run_d;
      wait_q        <= wait_d;
      inst_data_q   <= inst_data_d;
      mem_din_q     <= mem_din_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      ram_req_q     <= ram_req_d;
      ram_we_q      <= ram_we_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.inst_data   = inst_data_q;
  assign bus.mem_din     = mem_din_q;
  assign bus.ram_req     = ram_req_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_wdata   = ram_wdata_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.timeout_err = timeout_err_q;
  assign bus.inst_stall  = bus.inst_ren & (state_q != INST_RESP);
  assign bus.mem_stall   = data_pend & (state_q != DATA_RESP);

endmodule
